// File: rtl/la_readout_sequencer.sv
// Logic-analyzer dump: header word, then samples 0..cnt-1 read from RAM; RD_LAT+2 cycles per sample.
// valid/ready output holds a word until accepted; abort ends the dump via FIN without out_last.
module la_readout_sequencer #(
  parameter int          DEPTH   = 32,
  parameter int          AW      = 5,
  parameter int          RD_LAT  = 1,
  parameter logic [15:0] HDR_TAG = 16'hA55A
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [7:0]    la_status,
  output logic [AW-1:0] la_ai,
  input  logic [31:0]   la_dout,
  output logic [31:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_RADDR, S_RWAIT, S_PUSH, S_FIN
  } state_t;

  localparam logic [1:0]  LAT     = RD_LAT[1:0];
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

  state_t      r_state;
  state_t      w_next;
  logic [AW:0] r_cnt;
  logic [AW:0] r_index;
  logic [7:0]  r_status;
  logic [1:0]  r_wait;
  logic [31:0] r_data;
  logic [AW:0] w_snap;
  logic        w_hs;
  logic        w_last_idx;

  // Index is one bit wider than the address so a full buffer ends at DEPTH-1 without wrapping.
  assign la_ai      = r_index[AW-1:0];
  assign w_last_idx = (r_index == (r_cnt - ONE));
  assign w_hs       = out_valid & out_ready;

  always_comb begin
    w_snap = (AW+1)'(la_status[5:0]);
    if (int'(la_status[5:0]) > DEPTH) begin
      w_snap = DEPTH_C;
    end
  end

  always_comb begin
    out_valid = (r_state == S_HDR) || (r_state == S_PUSH);
    out_last  = ((r_state == S_HDR) && (r_cnt == '0)) ||
                ((r_state == S_PUSH) && w_last_idx);
    out_data  = (r_state == S_HDR) ? {HDR_TAG, 8'h00, r_status} : r_data;
    busy      = (r_state != S_IDLE) && (r_state != S_FIN);
    done      = (r_state == S_FIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Abort wins over a same-cycle handshake: the offered word is treated as not taken.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_HDR;
      S_HDR: begin
        if (abort)     w_next = S_FIN;
        else if (w_hs) w_next = (r_cnt == '0) ? S_FIN : S_RADDR;
      end
      S_RADDR: begin
        if (abort) w_next = S_FIN;
        else       w_next = (LAT == 2'd0) ? S_PUSH : S_RWAIT;
      end
      S_RWAIT: begin
        if (abort)                w_next = S_FIN;
        else if (r_wait == 2'd1)  w_next = S_PUSH;
      end
      S_PUSH: begin
        if (abort)     w_next = S_FIN;
        else if (w_hs) w_next = w_last_idx ? S_FIN : S_RADDR;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_index  <= '0;
      r_status <= '0;
      r_wait   <= '0;
      r_data   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt    <= w_snap;
            r_status <= la_status;
          end
        end
        S_HDR: begin
          if (w_hs && !abort) r_index <= '0;
        end
        S_RADDR: begin
          r_wait <= LAT;
          if (LAT == 2'd0) r_data <= la_dout;
        end
        S_RWAIT: begin
          r_wait <= r_wait - 2'd1;
          if (r_wait == 2'd1) r_data <= la_dout;
        end
        S_PUSH: begin
          if (w_hs && !abort && !w_last_idx) r_index <= r_index + ONE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_la_readout_sequencer.sv
// Bench for la_readout_sequencer: three builds (RD_LAT 0, 1, 3) driven by directed steps,
// each dump checked word-by-word against an expected word list built from the rules.
module tb_la_readout_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  la_status;
  logic        start_s     [3];
  logic        abort_s     [3];
  logic        out_ready_s [3];
  logic [4:0]  la_ai       [3];
  logic [31:0] la_dout     [3];
  logic [31:0] out_data    [3];
  logic        out_valid   [3];
  logic        out_last    [3];
  logic        busy        [3];
  logic        done        [3];
  logic [31:0] ram [3][32];

  int n_assert = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic [31:0] pipe [3];

    la_readout_sequencer #(
      .DEPTH(32), .AW(5), .RD_LAT(L), .HDR_TAG(16'hA55A)
    ) u_dut (
      .clk(clk), .reset(reset), .start(start_s[g]), .abort(abort_s[g]),
      .la_status(la_status), .la_ai(la_ai[g]), .la_dout(la_dout[g]),
      .out_data(out_data[g]), .out_valid(out_valid[g]), .out_ready(out_ready_s[g]),
      .out_last(out_last[g]), .busy(busy[g]), .done(done[g])
    );

    // RAM whose data only becomes valid L cycles after the address changes.
    always @(posedge clk) begin
      pipe[0] <= ram[g][la_ai[g]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign la_dout[g] = (L == 0) ? ram[g][la_ai[g]] : pipe[(L == 0) ? 0 : L - 1];
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int k, input bit mul3);
    for (int a = 0; a < 32; a++) ram[k][a] = mul3 ? 32'(a * 3) : $urandom;
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk({tag, "_valid"}, 32'(out_valid[k]), 32'd0);
    chk({tag, "_last"},  32'(out_last[k]),  32'd0);
    chk({tag, "_busy"},  32'(busy[k]),      32'd0);
    chk({tag, "_done"},  32'(done[k]),      32'd0);
    chk({tag, "_data"},  out_data[k],       32'd0);
    chk({tag, "_ai"},    32'(la_ai[k]),     32'd0);
  endtask

  // One dump on instance k. abort_w >= 0 aborts (with ready high) while word abort_w is offered.
  task automatic dump(input int k, input logic [7:0] st, input int pct,
                      input int abort_w, input bit rnd_start);
    logic [31:0] exp_q[$];
    int n, L, exp_w, cyc, last_hs;
    bit exp_done, fin, prev_v, prev_hs, v, ready, ab, hs;
    n = (st[5:0] > 6'd32) ? 32 : int'(st[5:0]);
    L = lat_of(k);
    exp_q = {};
    exp_q.push_back({16'hA55A, 8'h00, st});
    for (int i = 0; i < n; i++) exp_q.push_back(ram[k][i]);

    la_status  = st;
    start_s[k] = 1'b1;
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    la_status  = 8'($urandom);
    exp_w = 0; cyc = 0; last_hs = 0;
    exp_done = 0; fin = 0; prev_v = 0; prev_hs = 0;
    while (!fin) begin
      v = out_valid[k];
      chk("done", 32'(done[k]), 32'(exp_done));
      if (exp_done) begin
        chk("fin_busy",  32'(busy[k]),     32'd0);
        chk("fin_valid", 32'(v),           32'd0);
        chk("fin_last",  32'(out_last[k]), 32'd0);
        fin = 1;
      end else begin
        chk("busy", 32'(busy[k]), 32'd1);
        if (cyc == 0) chk("hdr_valid", 32'(v), 32'd1);
        if (prev_v && !prev_hs) chk("valid_hold", 32'(v), 32'd1);
        if (v) begin
          chk("data", out_data[k], exp_q[exp_w]);
          chk("last", 32'(out_last[k]), 32'(exp_w == n));
          if (exp_w > 0) chk("addr", 32'(la_ai[k]), 32'(exp_w - 1));
        end
        ready = ($urandom_range(99) < pct);
        ab    = (abort_w >= 0) && v && (exp_w == abort_w);
        if (ab) ready = 1'b1;
        hs = v && ready && !ab;
        if (hs) begin
          if (pct == 100 && exp_w > 0) chk("spacing", 32'(cyc - last_hs), 32'(L + 2));
          last_hs = cyc;
          if (exp_w == n) exp_done = 1;
          exp_w++;
        end
        if (ab) exp_done = 1;
        out_ready_s[k] = ready;
        abort_s[k]     = ab;
        start_s[k]     = rnd_start ? ($urandom_range(3) == 0) : 1'b0;
        prev_v  = v;
        prev_hs = hs || ab;
        @(posedge clk); #1;
        cyc++;
        if (cyc > 3000) begin
          n_assert++;
          n_fail++;
          $error("FAIL timeout: dump on instance %0d still running after %0d cycles", k, cyc);
          fin = 1;
        end
      end
      if (fin) begin
        out_ready_s[k] = 1'b0;
        abort_s[k]     = 1'b0;
        start_s[k]     = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done[k]),      32'd0);
    chk("idle_busy",      32'(busy[k]),      32'd0);
    chk("idle_valid",     32'(out_valid[k]), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    la_status = 8'h00;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; abort_s[k] = 1'b0; out_ready_s[k] = 1'b0;
      fill(k, 1'b0);
    end
    #12;
    for (int k = 0; k < 3; k++) chk_zero(k, "reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Three-sample dump with known data.
    ram[1][0] = 32'h11; ram[1][1] = 32'h22; ram[1][2] = 32'h33;
    dump(1, 8'h03, 100, -1, 1'b0);

    // Empty buffer: header alone carries out_last.
    dump(1, 8'hC0, 100, -1, 1'b0);

    // Full buffer with random stalls and stray start pulses.
    fill(1, 1'b0);
    dump(1, 8'h20, 50, -1, 1'b1);

    // Count field above DEPTH clamps to 32 samples.
    fill(1, 1'b0);
    dump(1, 8'h7F, 70, -1, 1'b0);

    // Abort on the third sample together with ready, then a fresh dump.
    fill(1, 1'b0);
    dump(1, 8'h05, 100, 3, 1'b0);
    dump(1, {2'($urandom), 6'($urandom_range(1, 8))}, 100, -1, 1'b0);

    // Reset while waiting on the second RAM read.
    fill(1, 1'b0);
    out_ready_s[1] = 1'b1;
    la_status      = 8'h04;
    start_s[1]     = 1'b1;
    @(posedge clk); #1;
    start_s[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rwait_ai",    32'(la_ai[1]),     32'd1);
    chk("rwait_valid", 32'(out_valid[1]), 32'd0);
    chk("rwait_busy",  32'(busy[1]),      32'd1);
    #2 reset = 1'b0;
    #1 chk_zero(1, "midreset");
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_done_after_reset", 32'(done[1]), 32'd0);
    end
    out_ready_s[1] = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    dump(1, 8'h01, 100, -1, 1'b0);

    // Zero and three cycle read latency builds, data = address*3.
    fill(0, 1'b1);
    dump(0, 8'h04, 100, -1, 1'b0);
    fill(2, 1'b1);
    dump(2, 8'h04, 100, -1, 1'b0);
    fill(2, 1'b0);
    dump(2, 8'h8A, 40, -1, 1'b0);
    fill(0, 1'b0);
    dump(0, 8'h4C, 60, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/la_readout_sequencer.md
LA_READOUT_SEQUENCER -- requirements
Module: la_readout_sequencer

Interface
REQ-001 Parameter DEPTH, 32, number of logic-analyzer sample RAM entries.
REQ-002 Parameter AW, 5, RAM address width; DEPTH SHALL equal 2**AW.
REQ-003 Parameter RD_LAT, 1, cycles from la_ai change to valid la_dout; legal range 0..3.
REQ-004 Parameter HDR_TAG, 16'hA55A, tag in header word bits [31:16].
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request to dump the capture buffer.
REQ-008 abort  in  1  stops an in-progress dump.
REQ-009 la_status  in  8  analyzer STATUS; bits [5:0] hold captured-sample count 0..32, bits [7:6] are carried in the header only.
REQ-010 la_ai  out  AW  read address to analyzer RAM.
REQ-011 la_dout  in  32  read data from analyzer RAM.
REQ-012 out_data  out  32  word offered to host.
REQ-013 out_valid  out  1  out_data is valid.
REQ-014 out_ready  in  1  host accepts word when out_valid and out_ready are both high.
REQ-015 out_last  out  1  marks final word of the dump; valid only with out_valid.
REQ-016 busy  out  1  high from the cycle after start is accepted until done.
REQ-017 done  out  1  one-cycle pulse at the end of a dump, including an aborted one.

Function
REQ-018 States: IDLE, HDR, RADDR, RWAIT, PUSH, FIN.
REQ-019 In IDLE, start SHALL snapshot cnt = min(la_status[5:0], DEPTH) and status_q = la_status, then go to HDR; start outside IDLE SHALL be ignored.
REQ-020 In HDR, out_data SHALL be {HDR_TAG, 8'h00, status_q}, out_valid = 1, and out_last = 1 iff cnt == 0.
REQ-021 On HDR handshake: cnt == 0 -> FIN, otherwise -> RADDR with index = 0.
REQ-022 In RADDR, la_ai SHALL equal index[AW-1:0]; next state RWAIT with wait counter = RD_LAT, or PUSH directly when RD_LAT == 0.
REQ-023 In RWAIT, la_ai SHALL be held and the counter decremented; on the cycle the counter reaches 0, la_dout SHALL be registered into out_data and the state SHALL move to PUSH.
REQ-024 In PUSH, out_valid = 1 and out_data SHALL stay stable while out_ready is low; out_last = 1 iff index == cnt-1.
REQ-025 On PUSH handshake: index == cnt-1 -> FIN, otherwise index SHALL increment and the state SHALL move to RADDR.
REQ-026 Throughput: one sample word per RD_LAT+2 cycles with out_ready held high.
REQ-027 FIN SHALL pulse done for one cycle, drop busy, and return to IDLE.
REQ-028 abort in any state except IDLE and FIN SHALL go to FIN next cycle and drop out_valid, with no out_last asserted; abort has priority over a same-cycle handshake, and that word SHALL count as not transferred.
REQ-029 la_status changes during a dump SHALL have no effect; only the snapshot is used.
REQ-030 Index SHALL be AW+1 bits wide so cnt = 32 reaches address 31 without wrapping; la_ai SHALL never exceed DEPTH-1.
REQ-031 out_valid SHALL never deassert without a handshake except on abort or reset.

Reset
REQ-032 While reset is low: state = IDLE, la_ai = 0, out_data = 0, out_valid = 0, out_last = 0, busy = 0, done = 0, cnt = 0, index = 0.
REQ-033 Reset asserted mid-dump SHALL abandon the dump immediately; no done pulse SHALL follow.

Verification
REQ-034 la_status = 8'h03, RAM[0..2] = 11,22,33, out_ready = 1, start pulse -> words A55A0003, 11, 22, 33; out_last only on 33; done one cycle later.
REQ-035 la_status = 8'hC0 (count 0), start -> single word A55A00C0 with out_last = 1, then done.
REQ-036 Count 32, out_ready toggled randomly -> 33 words, addresses 0..31 in order, out_data stable while stalled, no repeated or dropped word.
REQ-037 Count 5, abort asserted during the third PUSH together with out_ready -> no out_last, done pulses, busy low, second start begins a fresh dump with header.
REQ-038 Reset pulled low during RWAIT -> all outputs 0 asynchronously; after release, start with count 1 yields header and one word.
REQ-039 RD_LAT = 0 and RD_LAT = 3 builds, count 4, data = address*3 -> correct data, spacing of 2 and 5 cycles per word.
